quad_enc_reader: RTL and testbench

- Input-side counterpart of the board LED rotator: reads a mechanical quadrature rotary encoder (channels A/B) on two HX8K pins.
- Synchronizes and debounces both channels, then decodes x4 quadrature.
- Emits CW/CCW step pulses, a wrapping position count, and a one-hot 4-bit LED pattern that rotates one place per step.
- Sits between the encoder pins and the top-level LED outputs, clocked from the 12 MHz board clock.

---
 rtl/quad_enc_reader.sv | 168 ++++++++++++++++
 tb/tb_quad_enc_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_reader.sv
// Quadrature rotary encoder reader: two-flop sync, per-channel debounce,
// x4 Gray decode into step pulses, a wrapping position count and a rotating one-hot LED.
module quad_enc_reader #(
  parameter int DEBOUNCE_CYCLES = 1200,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  output logic                 step_cw,
  output logic                 step_ccw,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] position,
  output logic [3:0]           leds
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    PRIME,
    RUN
  } phase_t;

  phase_t               phase_q, phase_d;
  logic [1:0]           prime_cnt_q, prime_cnt_d;
  logic                 a_meta_q, a_meta_d;
  logic                 b_meta_q, b_meta_d;
  logic                 a_s_q, a_s_d;
  logic                 b_s_q, b_s_d;
  logic [DB_W-1:0]      a_cnt_q, a_cnt_d;
  logic [DB_W-1:0]      b_cnt_q, b_cnt_d;
  logic                 stable_a_q, stable_a_d;
  logic                 stable_b_q, stable_b_d;
  logic [1:0]           prev_q, prev_d;
  logic                 step_cw_q, step_cw_d;
  logic                 step_ccw_q, step_ccw_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] position_q, position_d;
  logic [3:0]           leds_q, leds_d;
  logic [1:0]           cur;

  assign cur = {stable_a_q, stable_b_q};

  always_comb begin
    phase_d     = phase_q;
    prime_cnt_d = prime_cnt_q;
    a_meta_d    = enc_a;
    b_meta_d    = enc_b;
    a_s_d       = a_meta_q;
    b_s_d       = b_meta_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    stable_a_d  = stable_a_q;
    stable_b_d  = stable_b_q;
    prev_d      = prev_q;
    step_cw_d   = 1'b0;
    step_ccw_d  = 1'b0;
    err_d       = 1'b0;
    position_d  = position_q;
    leds_d      = leds_q;

    case (phase_q)
      PRIME: begin
        // Adopt whatever the encoder rests at so the first RUN cycle sees no change.
        if (prime_cnt_q == 2'd2) begin
          stable_a_d  = a_s_q;
          stable_b_d  = b_s_q;
          prev_d      = {a_s_q, b_s_q};
          prime_cnt_d = 2'd0;
          phase_d     = RUN;
        end else begin
          prime_cnt_d = prime_cnt_q + 2'd1;
        end
      end

      RUN: begin
        if (a_s_q == stable_a_q) begin
          a_cnt_d = '0;
        end else if (a_cnt_q == DB_LAST) begin
          stable_a_d = a_s_q;
          a_cnt_d    = '0;
        end else begin
          a_cnt_d = a_cnt_q + DB_W'(1);
        end

        if (b_s_q == stable_b_q) begin
          b_cnt_d = '0;
        end else if (b_cnt_q == DB_LAST) begin
          stable_b_d = b_s_q;
          b_cnt_d    = '0;
        end else begin
          b_cnt_d = b_cnt_q + DB_W'(1);
        end

        prev_d = cur;
        // Index is {prev, cur}; CW follows 00->01->11->10->00.
        case ({prev_q, cur})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            step_cw_d  = 1'b1;
            position_d = position_q + CNT_WIDTH'(1);
            leds_d     = {leds_q[2:0], leds_q[3]};
          end
          4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
            step_ccw_d = 1'b1;
            position_d = position_q - CNT_WIDTH'(1);
            leds_d     = {leds_q[0], leds_q[3:1]};
          end
          4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
            err_d = 1'b1;
          end
          default: begin
          end
        endcase
      end

      default: begin
        phase_d = PRIME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PRIME;
      prime_cnt_q <= 2'd0;
      a_meta_q    <= 1'b0;
      b_meta_q    <= 1'b0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      stable_a_q  <= 1'b0;
      stable_b_q  <= 1'b0;
      prev_q      <= 2'b00;
      step_cw_q   <= 1'b0;
      step_ccw_q  <= 1'b0;
      err_q       <= 1'b0;
      position_q  <= '0;
      leds_q      <= 4'b0001;
    end else begin
      phase_q     <= phase_d;
      prime_cnt_q <= prime_cnt_d;
      a_meta_q    <= a_meta_d;
      b_meta_q    <= b_meta_d;
      a_s_q       <= a_s_d;
      b_s_q       <= b_s_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      stable_a_q  <= stable_a_d;
      stable_b_q  <= stable_b_d;
      prev_q      <= prev_d;
      step_cw_q   <= step_cw_d;
      step_ccw_q  <= step_ccw_d;
      err_q       <= err_d;
      position_q  <= position_d;
      leds_q      <= leds_d;
    end
  end

  assign step_cw  = step_cw_q;
  assign step_ccw = step_ccw_q;
  assign err      = err_q;
  assign position = position_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_quad_enc_reader.sv
// Scoreboard bench for quad_enc_reader: each encoder change pushes the expected pulse,
// position, LEDs and arrival cycle; a negedge monitor pops and compares as pulses appear.
module tb_quad_enc_reader;

  localparam int DB  = 4;
  localparam int W   = 8;
  localparam int LAT = DB + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enc_a = 1'b1;
  logic         enc_b = 1'b1;
  logic         step_cw;
  logic         step_ccw;
  logic         err;
  logic [W-1:0] position;
  logic [3:0]   leds;

  typedef struct {
    logic [2:0]   kind;
    logic [W-1:0] pos;
    logic [3:0]   leds;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cycle = 0;
  logic [1:0]   model_ab = 2'b11;
  logic [W-1:0] model_pos = '0;
  logic [3:0]   model_leds = 4'b0001;
  logic [1:0]   gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_enc_reader #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .step_cw(step_cw),
    .step_ccw(step_ccw),
    .err(err),
    .position(position),
    .leds(leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int gray_idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Bounce without modelling: the debouncer must swallow these.
  task automatic driveRaw(input logic a, input logic b, input int n);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int hold);
    logic [1:0] new_ab;
    int         dir;
    exp_t       e;
    @(negedge clk);
    enc_a  = a;
    enc_b  = b;
    new_ab = {a, b};
    if (new_ab != model_ab) begin
      dir = (gray_idx(new_ab) - gray_idx(model_ab) + 4) % 4;
      if (dir == 1) begin
        model_pos  = model_pos + 1'b1;
        model_leds = {model_leds[2:0], model_leds[3]};
        e.kind     = 3'b100;
      end else if (dir == 3) begin
        model_pos  = model_pos - 1'b1;
        model_leds = {model_leds[0], model_leds[3:1]};
        e.kind     = 3'b010;
      end else begin
        e.kind = 3'b001;
      end
      e.pos  = model_pos;
      e.leds = model_leds;
      e.due  = cycle + LAT;
      sb_q.push_back(e);
      model_ab = new_ab;
    end
    repeat (hold - 1) @(negedge clk);
    checkOutput("hold_position", 32'(position), 32'(model_pos));
    checkOutput("hold_leds", 32'(leds), 32'(model_leds));
  endtask

  task automatic stepCw(input int hold);
    logic [1:0] nxt;
    nxt = gray_tab[(gray_idx(model_ab) + 1) % 4];
    applyStimulus(nxt[1], nxt[0], hold);
  endtask

  task automatic stepCcw(input int hold);
    logic [1:0] nxt;
    nxt = gray_tab[(gray_idx(model_ab) + 3) % 4];
    applyStimulus(nxt[1], nxt[0], hold);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cw"}, 32'(step_cw), 32'd0);
    checkOutput({tag, "_ccw"}, 32'(step_ccw), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_position"}, 32'(position), 32'd0);
    checkOutput({tag, "_leds"}, 32'(leds), 32'b0001);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n      = 1'b1;
    model_ab   = {enc_a, enc_b};
    model_pos  = '0;
    model_leds = 4'b0001;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (step_cw || step_ccw || err) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_pulse", 32'({step_cw, step_ccw, err}), 32'd0);
        end else begin
          checkOutput("pulse_kind", 32'({step_cw, step_ccw, err}), 32'(sb_q[0].kind));
          checkOutput("pulse_latency", 32'(cycle), 32'(sb_q[0].due));
          checkOutput("pulse_position", 32'(position), 32'(sb_q[0].pos));
          checkOutput("pulse_leds", 32'(leds), 32'(sb_q[0].leds));
          void'(sb_q.pop_front());
        end
      end else if (sb_q.size() != 0 && cycle > sb_q[0].due) begin
        checkOutput("missing_pulse", 32'({step_cw, step_ccw, err}), 32'(sb_q[0].kind));
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    // Power-on reset with the encoder resting at 11.
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    releaseReset();
    repeat (200) @(negedge clk);
    checkOutput("idle_position", 32'(position), 32'd0);
    checkOutput("idle_leds", 32'(leds), 32'b0001);

    // One clean clockwise turn.
    for (int i = 0; i < 4; i++) stepCw(20);
    checkOutput("turn_position", 32'(position), 32'd4);
    checkOutput("turn_leds", 32'(leds), 32'b0001);

    // A bounces from 11 before settling low (11 -> 01 is one CCW step).
    driveRaw(1'b0, 1'b1, 2);
    driveRaw(1'b1, 1'b1, 2);
    driveRaw(1'b0, 1'b1, 2);
    driveRaw(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 20);
    stepCw(20);

    // Both channels flip together in each direction.
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 20);

    // Wrap both ways from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pending_before_wrap", 32'(sb_q.size()), 32'd0);
    releaseReset();
    repeat (10) @(negedge clk);
    stepCcw(20);
    checkOutput("wrap_down_position", 32'(position), 32'd255);
    checkOutput("wrap_down_leds", 32'(leds), 32'b1000);
    stepCw(10);
    for (int i = 0; i < 256; i++) stepCw(10);
    checkOutput("wrap_up_position", 32'(position), 32'd0);

    // Reset while A's debounce count sits at 2.
    stepCw(20);
    stepCw(20);
    driveRaw(~enc_a, enc_b, 5);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    checkOutput("pending_before_mid_reset", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    releaseReset();
    repeat (50) @(negedge clk);
    checkOutput("post_reset_position", 32'(position), 32'd0);
    checkOutput("post_reset_leds", 32'(leds), 32'b0001);
    stepCw(20);

    repeat (LAT + 2) @(negedge clk);
    checkOutput("pending_at_end", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
